// File: rtl/icache_pkg.sv
// Shared types and sizing helpers for the direct-mapped instruction cache.
// The FSM state type and the address-split widths live here so the top and
// the storage array agree on how a byte address is carved up.
package icache_pkg;

   // Controller states: serve hits, refill a line beat by beat, or deliver
   // the held request once the line is in place.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      REPLAY = 2'd2
   } state_e;

   localparam int DEF_LINES = 16;
   localparam int DEF_WORDS = 4;

   // Width of the word-offset field (selects a word inside a line).
   function automatic int offBits(input int words);
      return $clog2(words);
   endfunction

   // Width of the index field (selects a line).
   function automatic int idxBits(input int lines);
      return $clog2(lines);
   endfunction

   // Whatever is left of the 30-bit word address after offset and index.
   function automatic int tagBits(input int lines, input int words);
      return 30 - offBits(words) - idxBits(lines);
   endfunction

   localparam int OB = offBits(DEF_WORDS);
   localparam int IB = idxBits(DEF_LINES);
   localparam int TB = tagBits(DEF_LINES, DEF_WORDS);

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache bundled into
// one interface. The cache uses the slave view; whoever plays fetch stage
// and system memory uses the master view.
interface icache_if;

   logic [31:0] PcReq;
   logic        ReqVal;
   logic        Flush;
   logic        Invalidate;
   logic [31:0] InstrFill;
   logic        InstrVal;
   logic        Stall;
   logic        MemReq;
   logic [31:0] MemAddr;
   logic        MemAck;
   logic [31:0] MemData;

   modport slave (
      input  PcReq,
      input  ReqVal,
      input  Flush,
      input  Invalidate,
      input  MemAck,
      input  MemData,
      output InstrFill,
      output InstrVal,
      output Stall,
      output MemReq,
      output MemAddr
   );

   modport master (
      output PcReq,
      output ReqVal,
      output Flush,
      output Invalidate,
      output MemAck,
      output MemData,
      input  InstrFill,
      input  InstrVal,
      input  Stall,
      input  MemReq,
      input  MemAddr
   );

endinterface

// File: rtl/icache_array.sv
// Valid, tag and data storage for the cache. One combinational read port
// addressed by (index, offset), one write enable per word of the line being
// refilled, a tag/valid write port and a clear-all for invalidation.
module icache_array
   import icache_pkg::*;
#(
   parameter int LINES = DEF_LINES,
   parameter int WORDS = DEF_WORDS,
   localparam int OBW = offBits(WORDS),
   localparam int IBW = idxBits(LINES),
   localparam int TBW = tagBits(LINES, WORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IBW-1:0]   rdIndex_i,
   input  logic [OBW-1:0]   rdOffset_i,
   output logic             rdValid_o,
   output logic [TBW-1:0]   rdTag_o,
   output logic [31:0]      rdData_o,
   input  logic [IBW-1:0]   wrIndex_i,
   input  logic [WORDS-1:0] wrEn_i,
   input  logic [31:0]      wrData_i,
   input  logic             tagWe_i,
   input  logic [TBW-1:0]   wrTag_i,
   input  logic             clearAll_i
);

   logic [LINES-1:0] valid_q;
   logic [TBW-1:0]   tag_q  [LINES];
   logic [31:0]      data_q [LINES][WORDS];

   // Valid bits: set when a line's tag is written, all cleared by an
   // invalidate; clearing wins so a line installed on the same edge as an
   // invalidate ends up invalid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else begin
         if (tagWe_i) begin
            valid_q[wrIndex_i] <= 1'b1;
         end
         if (clearAll_i) begin
            valid_q <= '0;
         end
      end
   end

   // Tag storage needs no reset; a tag is only trusted alongside its valid bit.
   always_ff @(posedge clk) begin
      if (tagWe_i) begin
         tag_q[wrIndex_i] <= wrTag_i;
      end
   end

   // Data storage: each refill beat writes one word of the selected line.
   always_ff @(posedge clk) begin
      for (int w = 0; w < WORDS; w++) begin
         if (wrEn_i[w]) begin
            data_q[wrIndex_i][w] <= wrData_i;
         end
      end
   end

   assign rdValid_o = valid_q[rdIndex_i];
   assign rdTag_o   = tag_q[rdIndex_i];
   assign rdData_o  = data_q[rdIndex_i][rdOffset_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. Hits return the word one cycle
// after the request; a miss stalls fetch, refills the whole line from memory
// one acknowledged beat at a time, then replays the held request for a cycle.
module icache
   import icache_pkg::*;
#(
   parameter int LINES = DEF_LINES,
   parameter int WORDS = DEF_WORDS
) (
   input  logic     clk,
   input  logic     reset,
   icache_if.slave  bus
);

   localparam int OBW = offBits(WORDS);
   localparam int IBW = idxBits(LINES);
   localparam int TBW = tagBits(LINES, WORDS);

   state_e           state_q,   state_d;
   logic [OBW-1:0]   beat_q,    beat_d;
   logic [TBW-1:0]   reqTag_q,  reqTag_d;
   logic [IBW-1:0]   reqIdx_q,  reqIdx_d;
   logic [OBW-1:0]   reqOff_q,  reqOff_d;
   logic             cancel_q,  cancel_d;
   logic             invPend_q, invPend_d;
   logic             hitVal_q,  hitVal_d;
   logic [31:0]      fill_q,    fill_d;
   logic             stall_q,   stall_d;

   logic [OBW-1:0]   pcOff;
   logic [IBW-1:0]   pcIdx;
   logic [TBW-1:0]   pcTag;
   logic [IBW-1:0]   rdIdx;
   logic [OBW-1:0]   rdOff;
   logic             rdValid;
   logic [TBW-1:0]   rdTag;
   logic [31:0]      rdData;
   logic             tagHit;
   logic [WORDS-1:0] wrEn;
   logic             tagWe;
   logic             clearAll;
   logic             unusedPcBits;

   // The byte-lane bits of the fetch address carry no information.
   assign unusedPcBits = ^bus.PcReq[1:0];

   assign pcOff = bus.PcReq[OBW+1:2];
   assign pcIdx = bus.PcReq[OBW+IBW+1:OBW+2];
   assign pcTag = bus.PcReq[31:OBW+IBW+2];

   // During REPLAY the read port looks at the held request; otherwise it
   // looks at whatever fetch is presenting.
   assign rdIdx  = (state_q == REPLAY) ? reqIdx_q : pcIdx;
   assign rdOff  = (state_q == REPLAY) ? reqOff_q : pcOff;
   assign tagHit = rdValid && (rdTag == pcTag);

   icache_array #(
      .LINES (LINES),
      .WORDS (WORDS)
   ) u_array (
      .clk        (clk),
      .reset      (reset),
      .rdIndex_i  (rdIdx),
      .rdOffset_i (rdOff),
      .rdValid_o  (rdValid),
      .rdTag_o    (rdTag),
      .rdData_o   (rdData),
      .wrIndex_i  (reqIdx_q),
      .wrEn_i     (wrEn),
      .wrData_i   (bus.MemData),
      .tagWe_i    (tagWe),
      .wrTag_i    (reqTag_q),
      .clearAll_i (clearAll)
   );

   // Next-state logic: hit/miss decision in IDLE, beat sequencing in FILL,
   // and the one-cycle replay. Flush during a fill only cancels the replay;
   // an invalidate during a fill is remembered and applied on the install
   // edge so the freshly filled line does not survive it.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      reqTag_d  = reqTag_q;
      reqIdx_d  = reqIdx_q;
      reqOff_d  = reqOff_q;
      cancel_d  = cancel_q;
      invPend_d = invPend_q;
      hitVal_d  = 1'b0;
      fill_d    = fill_q;
      wrEn      = '0;
      tagWe     = 1'b0;
      clearAll  = bus.Invalidate;

      case (state_q)
         IDLE: begin
            if (bus.ReqVal && !bus.Flush) begin
               if (tagHit) begin
                  hitVal_d = 1'b1;
                  fill_d   = rdData;
               end else begin
                  reqTag_d  = pcTag;
                  reqIdx_d  = pcIdx;
                  reqOff_d  = pcOff;
                  beat_d    = '0;
                  cancel_d  = 1'b0;
                  invPend_d = 1'b0;
                  state_d   = FILL;
               end
            end
         end

         FILL: begin
            if (bus.Flush) begin
               cancel_d = 1'b1;
            end
            if (bus.Invalidate) begin
               invPend_d = 1'b1;
            end
            if (bus.MemAck) begin
               wrEn[beat_q] = 1'b1;
               beat_d       = beat_q + OBW'(1);
               if (beat_q == OBW'(WORDS - 1)) begin
                  tagWe = 1'b1;
                  if (invPend_q || bus.Invalidate) begin
                     clearAll = 1'b1;
                     state_d  = IDLE;
                  end else if (cancel_q || bus.Flush) begin
                     state_d  = IDLE;
                  end else begin
                     state_d  = REPLAY;
                  end
               end
            end
         end

         REPLAY: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      stall_d = (state_d == FILL);
   end

   // State, beat counter, held request, flags and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         beat_q    <= '0;
         reqTag_q  <= '0;
         reqIdx_q  <= '0;
         reqOff_q  <= '0;
         cancel_q  <= 1'b0;
         invPend_q <= 1'b0;
         hitVal_q  <= 1'b0;
         fill_q    <= '0;
         stall_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         reqTag_q  <= reqTag_d;
         reqIdx_q  <= reqIdx_d;
         reqOff_q  <= reqOff_d;
         cancel_q  <= cancel_d;
         invPend_q <= invPend_d;
         hitVal_q  <= hitVal_d;
         fill_q    <= fill_d;
         stall_q   <= stall_d;
      end
   end

   // Memory port is driven straight from registered state so it drops the
   // moment reset is asserted; the address reads as zero outside a fill.
   assign bus.MemReq  = (state_q == FILL);
   assign bus.MemAddr = (state_q == FILL) ? {reqTag_q, reqIdx_q, beat_q, 2'b00} : 32'h0;

   // Replay is delivered from the array in its own cycle and is squashed by
   // a flush arriving in that same cycle; hits come from the output register.
   assign bus.InstrVal  = (state_q == REPLAY) ? !bus.Flush : hitVal_q;
   assign bus.InstrFill = (state_q == REPLAY) ? rdData : fill_q;
   assign bus.Stall     = stall_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by randomized
// traffic, checked every cycle against a behavioural cache model (valid/tag
// per line, data implied by a fixed memory image).
module tb_icache;

   localparam int LINES = 16;
   localparam int WORDS = 4;
   localparam int OB    = 2;
   localparam int IB    = 4;

   logic clk = 1'b0;
   logic reset;

   icache_if bus ();

   icache #(
      .LINES (LINES),
      .WORDS (WORDS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cycleCnt = 0;
   int memReqCount = 0;
   int valCount = 0;
   logic [31:0] addrLog[$];
   int          valCycle[$];
   logic [31:0] valData[$];

   logic        chkEn = 1'b0;
   logic        expVal, expMemReq, expStall;
   logic [31:0] expFill, expAddr;

   logic        mValid[LINES];
   logic [31:0] mTag[LINES];
   logic        carryVal;
   logic [31:0] carryFill;

   // Fixed memory image: every word is easy to compute by hand.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic int idxOf(input logic [31:0] pc);
      return int'((pc >> (2 + OB)) % LINES);
   endfunction

   function automatic logic [31:0] tagOf(input logic [31:0] pc);
      return pc >> (2 + OB + IB);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cycleCnt);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
   endtask

   task automatic setExp(input logic v, input logic [31:0] f, input logic mr,
                         input logic [31:0] a, input logic st);
      expVal = v; expFill = f; expMemReq = mr; expAddr = a; expStall = st;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison against the model, plus event logs for the
   // directed literal checks.
   always @(negedge clk) begin
      cycleCnt++;
      if (chkEn) begin
         checkOutput("InstrVal", {31'b0, bus.InstrVal}, {31'b0, expVal});
         if (expVal) checkOutput("InstrFill", bus.InstrFill, expFill);
         checkOutput("MemReq", {31'b0, bus.MemReq}, {31'b0, expMemReq});
         checkOutput("Stall", {31'b0, bus.Stall}, {31'b0, expStall});
         if (expMemReq) checkOutput("MemAddr", bus.MemAddr, expAddr);
      end
      if (bus.MemReq === 1'b1) begin
         memReqCount++;
         addrLog.push_back(bus.MemAddr);
      end
      if (bus.InstrVal === 1'b1) begin
         valCount++;
         valCycle.push_back(cycleCnt);
         valData.push_back(bus.InstrFill);
      end
   end

   // One fetch transaction: the request cycle, then (on a miss) the whole
   // refill acting as memory with the given ack spacing, then the replay.
   task automatic applyStimulus(input logic [31:0] pc, input bit rv, input bit fl, input bit inv,
                                input int gap, input int flBeat, input int invBeat, input bit flReplay);
      int          idx;
      logic [31:0] tag, lineBase;
      bit          hit, miss, cancel, invPend, flDone, invDone, ack, f, i;
      int          beat, waitCnt;
      idx      = idxOf(pc);
      tag      = tagOf(pc);
      lineBase = pc & ~32'(WORDS * 4 - 1);

      bus.PcReq = pc; bus.ReqVal = rv; bus.Flush = fl; bus.Invalidate = inv;
      bus.MemAck = 1'($urandom_range(0, 1)); bus.MemData = $urandom;
      setExp(carryVal, carryFill, 1'b0, 32'h0, 1'b0);
      hit  = rv && mValid[idx] && (mTag[idx] == tag) && !fl;
      miss = rv && !fl && !hit;
      carryVal  = hit;
      carryFill = memWord({pc[31:2], 2'b00});
      if (inv) clearModel();
      tick();

      if (miss) begin
         cancel = 0; invPend = 0; beat = 0; waitCnt = gap; flDone = 0; invDone = 0;
         while (beat < WORDS) begin
            ack = (waitCnt == 0);
            f = (beat == flBeat) && !flDone;
            i = (beat == invBeat) && !invDone;
            if (f) flDone = 1;
            if (i) invDone = 1;
            bus.ReqVal = 1'b1; bus.PcReq = pc; bus.Flush = f; bus.Invalidate = i;
            bus.MemAck = ack;
            bus.MemData = ack ? memWord(lineBase + 32'(beat * 4)) : $urandom;
            setExp(1'b0, 32'h0, 1'b1, lineBase + 32'(beat * 4), 1'b1);
            if (f) cancel = 1;
            if (i) begin
               invPend = 1;
               clearModel();
            end
            tick();
            if (ack) begin
               beat++;
               waitCnt = gap;
            end else begin
               waitCnt--;
            end
         end
         mTag[idx]   = tag;
         mValid[idx] = !invPend;
         carryVal    = 1'b0;
         if (!cancel && !invPend) begin
            bus.ReqVal = 1'b1; bus.Flush = flReplay; bus.Invalidate = 1'b0;
            bus.MemAck = 1'($urandom_range(0, 1)); bus.MemData = $urandom;
            setExp(!flReplay, memWord({pc[31:2], 2'b00}), 1'b0, 32'h0, 1'b0);
            tick();
         end
      end
   endtask

   task automatic req(input logic [31:0] pc);
      applyStimulus(pc, 1'b1, 1'b0, 1'b0, 0, -1, -1, 1'b0);
   endtask

   task automatic idle(input bit inv);
      applyStimulus(32'h0, 1'b0, 1'b0, inv, 0, -1, -1, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      int          reqC, v0, mr0;
      logic [31:0] lastPc, pc;
      logic [31:0] expA[4];

      reset = 1'b0;
      bus.PcReq = '0; bus.ReqVal = 1'b0; bus.Flush = 1'b0; bus.Invalidate = 1'b0;
      bus.MemAck = 1'b0; bus.MemData = '0;
      clearModel();
      for (int i = 0; i < LINES; i++) mTag[i] = '0;
      carryVal = 1'b0; carryFill = '0;

      // Reset values.
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstInstrFill", bus.InstrFill, 32'h0);
      checkOutput("rstInstrVal", {31'b0, bus.InstrVal}, 32'h0);
      checkOutput("rstStall", {31'b0, bus.Stall}, 32'h0);
      checkOutput("rstMemReq", {31'b0, bus.MemReq}, 32'h0);
      checkOutput("rstMemAddr", bus.MemAddr, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      setExp(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chkEn = 1'b1;
      idle(1'b0);

      // Cold miss with zero-wait memory.
      $display("[TB] cold miss");
      addrLog.delete(); valCycle.delete(); valData.delete();
      reqC = cycleCnt + 1;
      req(32'h104);
      idle(1'b0);
      checkOutput("coldAddrCount", 32'(addrLog.size()), 32'd4);
      expA[0] = 32'h100; expA[1] = 32'h104; expA[2] = 32'h108; expA[3] = 32'h10C;
      for (int i = 0; i < 4; i++)
         if (i < addrLog.size()) checkOutput("coldMemAddr", addrLog[i], expA[i]);
      checkOutput("coldValCount", 32'(valCycle.size()), 32'd1);
      if (valCycle.size() > 0) begin
         checkOutput("coldLatency", 32'(valCycle[0] - reqC), 32'd5);
         checkOutput("coldData", valData[0], 32'h0104_FEFB);
      end

      // Hit stream.
      $display("[TB] hit stream");
      valCycle.delete(); valData.delete();
      mr0 = memReqCount;
      req(32'h100); req(32'h104); req(32'h108); req(32'h10C);
      idle(1'b0);
      checkOutput("hitValCount", 32'(valCycle.size()), 32'd4);
      if (valCycle.size() == 4) begin
         checkOutput("hitSpan", 32'(valCycle[3] - valCycle[0]), 32'd3);
         checkOutput("hitData3", valData[3], 32'h010C_FEF3);
      end
      checkOutput("hitNoMemReq", 32'(memReqCount - mr0), 32'd0);

      // Conflict eviction in line 0.
      $display("[TB] conflict eviction");
      addrLog.delete();
      req(32'h200);
      checkOutput("evictAddrCount", 32'(addrLog.size()), 32'd4);
      if (addrLog.size() > 3) begin
         checkOutput("evictAddr0", addrLog[0], 32'h200);
         checkOutput("evictAddr3", addrLog[3], 32'h20C);
      end
      mr0 = memReqCount;
      req(32'h100);
      checkOutput("evictRemiss", 32'(memReqCount - mr0), 32'd4);

      // Flush during a fill with ack every other cycle.
      $display("[TB] flush during fill");
      v0 = valCount;
      applyStimulus(32'hC4, 1'b1, 1'b0, 1'b0, 1, 1, -1, 1'b0);
      idle(1'b0);
      checkOutput("flushNoReplay", 32'(valCount - v0), 32'd0);
      mr0 = memReqCount;
      req(32'hC8);
      idle(1'b0);
      checkOutput("flushThenHit", 32'(valCount - v0), 32'd1);
      checkOutput("flushHitNoMem", 32'(memReqCount - mr0), 32'd0);
      if (valData.size() > 0) checkOutput("flushHitData", valData[$], 32'h00C8_FF37);

      // Invalidate after filling two lines.
      $display("[TB] invalidate");
      req(32'h040); req(32'h080);
      idle(1'b1);
      mr0 = memReqCount;
      req(32'h044); req(32'h088);
      checkOutput("invBothMiss", 32'(memReqCount - mr0), 32'd8);

      // Reset asserted in beat 2 of a fill.
      $display("[TB] reset mid-fill");
      bus.PcReq = 32'h300; bus.ReqVal = 1'b1; bus.Flush = 1'b0; bus.Invalidate = 1'b0; bus.MemAck = 1'b0;
      setExp(carryVal, carryFill, 1'b0, 32'h0, 1'b0);
      tick();
      for (int b = 0; b < 2; b++) begin
         bus.MemAck = 1'b1; bus.MemData = memWord(32'h300 + 32'(b * 4));
         setExp(1'b0, 32'h0, 1'b1, 32'h300 + 32'(b * 4), 1'b1);
         tick();
      end
      chkEn = 1'b0;
      bus.MemAck = 1'b0;
      reset = 1'b0;
      #1;
      checkOutput("asyncMemReq", {31'b0, bus.MemReq}, 32'h0);
      checkOutput("asyncStall", {31'b0, bus.Stall}, 32'h0);
      checkOutput("asyncInstrVal", {31'b0, bus.InstrVal}, 32'h0);
      bus.ReqVal = 1'b0;
      setExp(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chkEn = 1'b1;
      tick();
      reset = 1'b1;
      clearModel();
      carryVal = 1'b0;
      mr0 = memReqCount;
      req(32'h308);
      checkOutput("rstLineInvalid", 32'(memReqCount - mr0), 32'd4);

      // Randomized traffic.
      $display("[TB] random traffic");
      lastPc = 32'h100;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) < 15) begin
            applyStimulus(32'($urandom), 1'b0, ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 15) == 0), 0, -1, -1, 1'b0);
         end else begin
            if ($urandom_range(0, 1) == 0) pc = lastPc + 32'd4;
            else pc = 32'($urandom_range(0, 511)) << 2;
            pc = pc & 32'h7FC;
            lastPc = pc;
            pc = pc | 32'($urandom_range(0, 3));
            applyStimulus(pc, 1'b1, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                          $urandom_range(0, 2),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1,
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1,
                          ($urandom_range(0, 5) == 0));
         end
      end
      idle(1'b0);
      chkEn = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
